// File: rtl/param_alu_if.sv
// Command/result bundle between the issue stage and the param_alu execute unit.
// The issuing side drives command and operands; the ALU returns status, result and flags.
interface param_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, result, zero, negative, carry, overflow
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/param_alu.sv
// Parametrised integer execute unit: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring unsigned divide with fixed latency.
//
// state | meaning
// IDLE  | ready for a command; single-cycle ops complete from here
// EXEC  | iterative MUL/MULHU/DIVU/REMU running, one step per cycle
module param_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  param_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [0:0] {IDLE, EXEC} state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q, neg_q, carry_q, ovf_q, done_q;

  logic               accept, start_iter, last_iter, is_mul_q;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum_add, sum_sub;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;
  logic [WIDTH-1:0]   div_diff;
  logic               div_neg;
  logic [WIDTH-1:0]   iter_res;
  logic [WIDTH-1:0]   fin_res;

  assign accept     = bus.start && (state == IDLE);
  assign start_iter = (bus.op >= OP_MUL) && (bus.op <= OP_REMU);
  assign last_iter  = (cnt == CW'(WIDTH - 1));
  assign is_mul_q   = (op_q == OP_MUL) || (op_q == OP_MULHU);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && start_iter) state_nxt = EXEC;
      EXEC: if (last_iter)            state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  assign sh      = bus.b[SHW-1:0];
  assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};
  assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.a << sh;
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SRA:  alu_res = $signed(bus.a) >>> sh;
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
  assign div_neg  = (acc[2*WIDTH-1:WIDTH-1] < {1'b0, opnd});
  assign div_diff = acc[2*WIDTH-2:WIDTH-1] - opnd;
  assign div_nxt  = div_neg ? {acc[2*WIDTH-2:0], 1'b0}
                            : {div_diff, acc[WIDTH-2:0], 1'b1};

  always_comb begin
    iter_res = '0;
    case (op_q)
      OP_MUL:   iter_res = mul_nxt[WIDTH-1:0];
      OP_MULHU: iter_res = mul_nxt[2*WIDTH-1:WIDTH];
      OP_DIVU:  iter_res = div_nxt[WIDTH-1:0];
      OP_REMU:  iter_res = div_nxt[2*WIDTH-1:WIDTH];
      default:  iter_res = '0;
    endcase
  end

  assign fin_res = (state == IDLE) ? alu_res : iter_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      opnd    <= '0;
      acc     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && start_iter) begin
        op_q <= bus.op;
        cnt  <= '0;
        if ((bus.op == OP_MUL) || (bus.op == OP_MULHU)) begin
          opnd <= bus.a;
          acc  <= {{WIDTH{1'b0}}, bus.b};
        end else begin
          opnd <= bus.b;
          acc  <= {{WIDTH{1'b0}}, bus.a};
        end
      end else if (accept) begin
        res_q   <= fin_res;
        zero_q  <= (fin_res == '0);
        neg_q   <= fin_res[WIDTH-1];
        carry_q <= alu_c;
        ovf_q   <= alu_v;
        done_q  <= 1'b1;
      end else if (state == EXEC) begin
        acc <= is_mul_q ? mul_nxt : div_nxt;
        cnt <= cnt + CW'(1);
        if (last_iter) begin
          res_q   <= fin_res;
          zero_q  <= (fin_res == '0);
          neg_q   <= fin_res[WIDTH-1];
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state == EXEC);
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/param_alu.md
# param_alu

Parametrised, multi-cycle integer execute unit for the RISC-V datapath. It generalises the single-cycle 32-bit ALU in three ways: the operand width is a parameter, the operation set covers XOR, the unsigned compare and the shifts, and it adds iterative multiply and unsigned divide. Each operation starts with a one-cycle command and signals its result with a one-cycle done pulse. The block sits between the decode/register-read stage and write-back; the pipeline stalls on `ready`=0.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be a power of two, ≥ 8.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only when `ready`=1.
- `op`  in  4  operation code, sampled with `start`.
- `a`, `b`  in  WIDTH  operands, sampled with `start`.
- `ready`  out  1  FSM in IDLE; a command can be accepted.
- `busy`  out  1  FSM in EXEC (iterative operation running).
- `done`  out  1  one-cycle pulse; `result` and the flags are valid in this cycle.
- `result`  out  WIDTH  registered result, held until the next `done`.
- `zero`, `negative`, `carry`, `overflow`  out  1 each  registered flags, updated only with `done`.

## Operation
Op codes:
- 0 ADD.
- 1 SUB.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SLT (signed).
- 6 SLTU.
- 7 SLL.
- 8 SRL.
- 9 SRA.
- 10 MUL (low WIDTH bits of the product).
- 11 MULHU (high WIDTH bits of the unsigned product).
- 12 DIVU.
- 13 REMU.
- 14-15 reserved: result = 0, handled as a single-cycle operation.

Operation rules:
- Shifts use `b[$clog2(WIDTH)-1:0]`; upper bits of `b` are ignored.
- SUB is computed as a + ~b + 1.
- SLT/SLTU return 0 or 1, zero-extended to WIDTH.

Flags:
- `carry`: for ADD, carry-out; for SUB, carry-out of a + ~b + 1 (1 means a ≥ b unsigned). 0 for all other ops.
- `overflow`: signed overflow for ADD/SUB only, else 0.
- `zero` = (result == 0); `negative` = result[WIDTH-1]. Both apply to every op.

FSM states: IDLE, EXEC.
- IDLE & `start` & single-cycle op: compute, register the result and flags, pulse `done` on the next cycle, stay in IDLE.
- IDLE & `start` & op 10-13: latch the operands, clear the accumulator and counter, go to EXEC.
- EXEC: one iteration per cycle.
  - MUL/MULHU: shift-add over a 2·WIDTH-bit product.
  - DIVU/REMU: restoring division, one quotient bit per cycle.
  - After WIDTH iterations: register the result and flags, pulse `done`, return to IDLE.
- Iterative ops run exactly WIDTH iterations (fixed latency); there is no early termination.
- Divide by zero: DIVU → all ones; REMU → `a`. Latency is unchanged.
- `start` while `ready`=0 is ignored; no queueing.
- Iteration counter is `$clog2(WIDTH)+1` bits and must not wrap before WIDTH iterations.

## Timing
- Reset values: state IDLE, `result`=0, all flags 0, `done`=0, `busy`=0, counter/accumulator 0. `ready`=1 from the first cycle after reset.
- Single-cycle ops: `start` accepted at edge N → `done`=1 with valid `result` during cycle N+1.
- Iterative ops: `start` at edge N → `busy`=1 for cycles N+1 … N+WIDTH; `done`=1 during cycle N+WIDTH+1, together with `ready`=1 and `busy`=0.
- `ready` is combinational from state: a new `start` in the `done` cycle is accepted, giving back-to-back throughput.
- `done` is never asserted for two consecutive cycles by the same command.
- Reset mid-EXEC: the operation is aborted, no `done` is produced, and the outputs take their reset values on the next edge.
- `rst` and `start` in the same cycle: reset wins; the command is dropped.
- Operands may change after acceptance without affecting the operation.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 (WIDTH=32) → `result`=0x80000000, `overflow`=1, `negative`=1, `carry`=0, `zero`=0; `done` at N+1.
- SUB 5 − 5 → `result`=0, `zero`=1, `carry`=1, `overflow`=0. Then SLT 0xFFFFFFFF, 1 → 1; SLTU with the same operands → 0; SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001; MULHU with the same operands → 0xFFFFFFFE. `busy` is high for 32 cycles and `done` arrives at N+33.
- DIVU 100 / 7 → 14; REMU → 2. DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9, both at N+33.
- Pulse `start` during EXEC → ignored, and the original result is unchanged. Assert `rst` at cycle 10 of a DIVU → no `done`; `ready`=1 on the next cycle. Issue a new ADD in the `done` cycle → accepted, with its `done` one cycle later.
- Build with WIDTH=8: MUL 0x0F × 0x11 → 0xFF with `done` at N+9; ADD 0xFF + 0x01 → 0x00, `carry`=1, `zero`=1.
